// File: rtl/chi5pc_req_tgtid_check.sv
// CHI5 REQ TgtID checker: region-table expected TgtID compare plus link-credit tracking.
// Optional first-mismatch log enabled by defining CHI5PC_REQ_TGTID_LOG_EN.

module chi5pc_req_region_ent #(
    parameter int ADDR_W = 44,
    parameter int NID_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic [NID_W-1:0]  cfg_tgt,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [NID_W-1:0]  tgt
);
    logic              en;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en   <= 1'b0;
            base <= '0;
            mask <= '0;
            tgt  <= '0;
        end else if (wr) begin
            en   <= cfg_en;
            base <= cfg_base;
            mask <= cfg_mask;
            tgt  <= cfg_tgt;
        end
    end

    assign hit = en && ((addr & mask) == (base & mask));
endmodule

module chi5pc_req_tgtid_check #(
    parameter int ADDR_W      = 44,
    parameter int NID_W       = 7,
    parameter int OPC_W       = 6,
    parameter int NUM_REG     = 8,
    parameter int MAX_CRD     = 15,
    parameter int DEFAULT_TGT = 0
) (
    input  logic              SCLK,
    input  logic              SRESET,
    input  logic              REQFLITV,
    input  logic [OPC_W-1:0]  REQ_OPCODE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [NID_W-1:0]  REQ_TGTID,
    input  logic              REQLCRDV,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_idx,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic [NID_W-1:0]  cfg_tgt,
    input  logic              cfg_en,
    output logic              exp_valid,
    output logic [NID_W-1:0]  exp_tgtid,
    output logic              err_tgtid,
    output logic              err_no_crd,
    output logic              err_crd_ovf,
    output logic [3:0]        crd_cnt,
    output logic [15:0]       mis_cnt,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [NID_W-1:0]  log_exp,
    output logic [NID_W-1:0]  log_act
);
    localparam int STAGES = 1;

    localparam logic [OPC_W-1:0] OPC_LCRDRET  = OPC_W'('h00);
    localparam logic [OPC_W-1:0] OPC_EOBARR   = OPC_W'('h0C);
    localparam logic [OPC_W-1:0] OPC_ECBARR   = OPC_W'('h0D);
    localparam logic [OPC_W-1:0] OPC_DVMOP    = OPC_W'('h14);

    logic [STAGES:0]   vld_pipe;
    logic [OPC_W-1:0]  s1_opc;
    logic [ADDR_W-1:0] s1_addr;
    logic [NID_W-1:0]  s1_tgt;

    logic [NUM_REG-1:0]            ent_hit;
    logic [NUM_REG-1:0][NID_W-1:0] ent_tgt;
    logic [NID_W-1:0]              lk_tgt;

    logic             s2_pass;
    logic             s2_ev;
    logic [NID_W-1:0] s2_exp;
    logic             s2_err;

    // S1: capture the flit; vld_pipe[0] marks S1 occupancy, vld_pipe[1] drives exp_valid.
    always_ff @(posedge SCLK or posedge SRESET) begin
        if (SRESET) begin
            vld_pipe[0] <= 1'b0;
            s1_opc      <= '0;
            s1_addr     <= '0;
            s1_tgt      <= '0;
        end else begin
            vld_pipe[0] <= REQFLITV;
            if (REQFLITV) begin
                s1_opc  <= REQ_OPCODE;
                s1_addr <= REQ_ADDR;
                s1_tgt  <= REQ_TGTID;
            end
        end
    end

    for (genvar i = 0; i < NUM_REG; i++) begin : g_ent
        chi5pc_req_region_ent #(
            .ADDR_W (ADDR_W),
            .NID_W  (NID_W)
        ) u_ent (
            .clk      (SCLK),
            .rst      (SRESET),
            .wr       (cfg_wr && (cfg_idx == 4'(i))),
            .cfg_base (cfg_base),
            .cfg_mask (cfg_mask),
            .cfg_tgt  (cfg_tgt),
            .cfg_en   (cfg_en),
            .addr     (s1_addr),
            .hit      (ent_hit[i]),
            .tgt      (ent_tgt[i])
        );
    end

    // Descending scan so the lowest-index hit wins.
    always_comb begin
        lk_tgt = NID_W'(DEFAULT_TGT);
        for (int i = NUM_REG - 1; i >= 0; i--) begin
            if (ent_hit[i]) lk_tgt = ent_tgt[i];
        end
    end

    assign s2_pass = (s1_opc == OPC_EOBARR) || (s1_opc == OPC_ECBARR) || (s1_opc == OPC_DVMOP);
    assign s2_ev   = vld_pipe[0] && (s1_opc != OPC_LCRDRET);
    assign s2_exp  = s2_pass ? s1_tgt : lk_tgt;
    assign s2_err  = s2_ev && (s2_exp != s1_tgt);

    // S2: register compare results.
    always_ff @(posedge SCLK or posedge SRESET) begin
        if (SRESET) begin
            vld_pipe[STAGES] <= 1'b0;
            exp_tgtid        <= '0;
            err_tgtid        <= 1'b0;
            mis_cnt          <= '0;
        end else begin
            vld_pipe[STAGES] <= s2_ev;
            err_tgtid        <= s2_err;
            if (s2_ev) exp_tgtid <= s2_exp;
            if (s2_err && (mis_cnt != 16'hFFFF)) mis_cnt <= mis_cnt + 16'd1;
        end
    end

    assign exp_valid = vld_pipe[STAGES];

    // Credits: a grant in the same cycle as a flit at zero cannot cover that flit.
    always_ff @(posedge SCLK or posedge SRESET) begin
        if (SRESET) begin
            crd_cnt     <= '0;
            err_no_crd  <= 1'b0;
            err_crd_ovf <= 1'b0;
        end else begin
            err_no_crd  <= 1'b0;
            err_crd_ovf <= 1'b0;
            case ({REQLCRDV, REQFLITV})
                2'b10: begin
                    if (crd_cnt == 4'(MAX_CRD)) err_crd_ovf <= 1'b1;
                    else                         crd_cnt     <= crd_cnt + 4'd1;
                end
                2'b01: begin
                    if (crd_cnt == 4'd0) err_no_crd <= 1'b1;
                    else                 crd_cnt    <= crd_cnt - 4'd1;
                end
                2'b11: begin
                    if (crd_cnt == 4'd0) begin
                        err_no_crd <= 1'b1;
                        crd_cnt    <= 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHI5PC_REQ_TGTID_LOG_EN
    always_ff @(posedge SCLK or posedge SRESET) begin
        if (SRESET) begin
            log_valid <= 1'b0;
            log_addr  <= '0;
            log_exp   <= '0;
            log_act   <= '0;
        end else if (s2_err && !log_valid) begin
            log_valid <= 1'b1;
            log_addr  <= s1_addr;
            log_exp   <= s2_exp;
            log_act   <= s1_tgt;
        end
    end
`else
    assign log_valid = 1'b0;
    assign log_addr  = '0;
    assign log_exp   = '0;
    assign log_act   = '0;
`endif
endmodule

// File: tb/tb_chi5pc_req_tgtid_check.sv
// Directed bench for chi5pc_req_tgtid_check: lookup, pass-through, credits, reset flush.
module tb_chi5pc_req_tgtid_check;
    logic        SCLK = 1'b0;
    logic        SRESET;
    logic        REQFLITV;
    logic [5:0]  REQ_OPCODE;
    logic [43:0] REQ_ADDR;
    logic [6:0]  REQ_TGTID;
    logic        REQLCRDV;
    logic        cfg_wr;
    logic [3:0]  cfg_idx;
    logic [43:0] cfg_base;
    logic [43:0] cfg_mask;
    logic [6:0]  cfg_tgt;
    logic        cfg_en;
    logic        exp_valid;
    logic [6:0]  exp_tgtid;
    logic        err_tgtid;
    logic        err_no_crd;
    logic        err_crd_ovf;
    logic [3:0]  crd_cnt;
    logic [15:0] mis_cnt;
    logic        log_valid;
    logic [43:0] log_addr;
    logic [6:0]  log_exp;
    logic [6:0]  log_act;

    int checks = 0;
    int failures = 0;

    chi5pc_req_tgtid_check dut (
        .SCLK(SCLK), .SRESET(SRESET), .REQFLITV(REQFLITV), .REQ_OPCODE(REQ_OPCODE),
        .REQ_ADDR(REQ_ADDR), .REQ_TGTID(REQ_TGTID), .REQLCRDV(REQLCRDV),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
        .cfg_tgt(cfg_tgt), .cfg_en(cfg_en), .exp_valid(exp_valid), .exp_tgtid(exp_tgtid),
        .err_tgtid(err_tgtid), .err_no_crd(err_no_crd), .err_crd_ovf(err_crd_ovf),
        .crd_cnt(crd_cnt), .mis_cnt(mis_cnt), .log_valid(log_valid), .log_addr(log_addr),
        .log_exp(log_exp), .log_act(log_act)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    // Drives one flit for one cycle; on return the flit sits in S1.
    task automatic send(input logic [5:0] op, input logic [43:0] a, input logic [6:0] t);
        REQFLITV = 1'b1; REQ_OPCODE = op; REQ_ADDR = a; REQ_TGTID = t;
        tick();
        REQFLITV = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] idx, input logic [43:0] b, input logic [43:0] m,
                       input logic [6:0] t, input logic en);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_base = b; cfg_mask = m; cfg_tgt = t; cfg_en = en;
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        SRESET = 1'b1; REQFLITV = 0; REQ_OPCODE = 0; REQ_ADDR = 0; REQ_TGTID = 0;
        REQLCRDV = 0; cfg_wr = 0; cfg_idx = 0; cfg_base = 0; cfg_mask = 0; cfg_tgt = 0; cfg_en = 0;
        tick(); tick();
        chk("rst_exp_valid", exp_valid, 0);
        chk("rst_err_tgtid", err_tgtid, 0);
        chk("rst_crd", crd_cnt, 0);
        chk("rst_mis", mis_cnt, 0);
        chk("rst_errs", {err_no_crd, err_crd_ovf, log_valid}, 0);
        SRESET = 1'b0;
        tick();

        // Credits
        REQLCRDV = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        REQLCRDV = 1'b0;
        chk("crd_full", crd_cnt, 15);
        chk("crd_full_no_ovf", err_crd_ovf, 0);
        REQLCRDV = 1'b1; tick(); REQLCRDV = 1'b0;
        chk("crd_ovf_pulse", err_crd_ovf, 1);
        chk("crd_ovf_hold", crd_cnt, 15);
        tick();
        chk("crd_ovf_one_cycle", err_crd_ovf, 0);
        REQFLITV = 1'b1; REQ_OPCODE = 6'h14; REQ_ADDR = 0; REQ_TGTID = 7'h01;
        for (int i = 0; i < 15; i++) tick();
        REQFLITV = 1'b0;
        chk("crd_drained", crd_cnt, 0);
        chk("crd_drained_no_err", err_no_crd, 0);
        tick();
        REQFLITV = 1'b1; tick(); REQFLITV = 1'b0;
        chk("no_crd_pulse", err_no_crd, 1);
        chk("no_crd_hold", crd_cnt, 0);
        tick();
        chk("no_crd_one_cycle", err_no_crd, 0);
        REQFLITV = 1'b1; REQLCRDV = 1'b1; tick(); REQFLITV = 1'b0; REQLCRDV = 1'b0;
        chk("both_at_zero_err", err_no_crd, 1);
        chk("both_at_zero_cnt", crd_cnt, 1);
        REQLCRDV = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        REQLCRDV = 1'b0;
        tick(); tick();
        chk("dvm_flits_no_mis", mis_cnt, 0);

        // Region lookup
        cfg(4'd0, 44'h0_1000_0000, 44'hF_F000_0000, 7'd5, 1'b1);
        send(6'h04, 44'h0_1000_0040, 7'd5);
        chk("lat_not_yet", exp_valid, 0);
        tick();
        chk("hit_exp_valid", exp_valid, 1);
        chk("hit_exp_tgt", exp_tgtid, 5);
        chk("hit_no_err", err_tgtid, 0);

        send(6'h04, 44'h0_1000_0040, 7'd3);
        chk("mis_not_yet", err_tgtid, 0);
        tick();
        chk("mis_err", err_tgtid, 1);
        chk("mis_cnt1", mis_cnt, 1);
        tick();
        chk("mis_one_cycle", err_tgtid, 0);
`ifdef CHI5PC_REQ_TGTID_LOG_EN
        chk("log_valid", log_valid, 1);
        chk("log_exp", log_exp, 5);
        chk("log_act", log_act, 3);
        chk("log_addr", log_addr, 44'h0_1000_0040);
`endif
        send(6'h04, 44'h0_1000_0080, 7'd4);
        tick();
        chk("mis2_err", err_tgtid, 1);
        chk("mis_cnt2", mis_cnt, 2);
`ifdef CHI5PC_REQ_TGTID_LOG_EN
        chk("log_sticky_act", log_act, 3);
        chk("log_sticky_addr", log_addr, 44'h0_1000_0040);
`else
        chk("log_tied_off", {log_valid, log_addr, log_exp, log_act}, 0);
`endif

        // Overlap priority: lowest enabled index wins
        cfg(4'd0, 44'h0_1000_0000, 44'hF_F000_0000, 7'd5, 1'b0);
        cfg(4'd2, 44'h0_1000_0000, 44'hF_FFFF_0000, 7'd7, 1'b1);
        cfg(4'd1, 44'h0_1000_0000, 44'hF_FF00_0000, 7'd9, 1'b1);
        send(6'h04, 44'h0_1000_0000, 7'd9);
        tick();
        chk("overlap_tgt", exp_tgtid, 9);
        chk("overlap_no_err", err_tgtid, 0);
        cfg(4'd1, 44'h0_1000_0000, 44'hF_FF00_0000, 7'd9, 1'b0);
        send(6'h04, 44'h0_1000_0000, 7'd7);
        tick();
        chk("next_entry_tgt", exp_tgtid, 7);
        cfg(4'd9, 44'h0_2000_0000, 44'hF_F000_0000, 7'd3, 1'b1);
        send(6'h04, 44'h0_2000_0000, 7'd0);
        tick();
        chk("nohit_valid", exp_valid, 1);
        chk("nohit_default", exp_tgtid, 0);
        chk("nohit_no_err", err_tgtid, 0);

        // Pass-through and credit-return opcodes
        send(6'h14, 44'h0_3000_0000, 7'h22);
        tick();
        chk("dvm_tgt", exp_tgtid, 7'h22);
        chk("dvm_no_err", err_tgtid, 0);
        send(6'h0C, 44'h0_3000_0000, 7'h31);
        tick();
        chk("barrier_tgt", exp_tgtid, 7'h31);
        send(6'h00, 44'h0_1000_0000, 7'h55);
        tick();
        chk("lcrdret_no_valid", exp_valid, 0);
        chk("lcrdret_no_err", err_tgtid, 0);

        // Table write timing
        REQFLITV = 1'b1; REQ_OPCODE = 6'h04; REQ_ADDR = 44'h0_1000_0000; REQ_TGTID = 7'h11;
        cfg_wr = 1'b1; cfg_idx = 4'd2; cfg_base = 44'h0_1000_0000;
        cfg_mask = 44'hF_FFFF_0000; cfg_tgt = 7'h11; cfg_en = 1'b1;
        tick();
        REQFLITV = 1'b0; cfg_wr = 1'b0;
        tick();
        chk("wr_before_s2_new", exp_tgtid, 7'h11);
        send(6'h04, 44'h0_1000_0000, 7'h11);
        cfg(4'd2, 44'h0_1000_0000, 44'hF_FFFF_0000, 7'h12, 1'b1);
        chk("wr_during_s2_old", exp_tgtid, 7'h11);
        chk("wr_during_s2_no_err", err_tgtid, 0);

        // Back-to-back
        REQFLITV = 1'b1; REQ_OPCODE = 6'h04; REQ_ADDR = 44'h0_1000_0000; REQ_TGTID = 7'h12;
        tick();
        REQ_ADDR = 44'h0_2000_0000; REQ_TGTID = 7'h00;
        tick();
        REQFLITV = 1'b0;
        chk("b2b_first", exp_tgtid, 7'h12);
        tick();
        chk("b2b_second", exp_tgtid, 0);
        chk("b2b_second_valid", exp_valid, 1);
        chk("pre_reset_mis", mis_cnt, 2);

        // Reset with a mismatching flit in S1
        send(6'h04, 44'h0_2000_0000, 7'd9);
        SRESET = 1'b1;
        tick();
        chk("midrst_no_err", err_tgtid, 0);
        chk("midrst_no_valid", exp_valid, 0);
        SRESET = 1'b0;
        tick();
        chk("postrst_no_err", err_tgtid, 0);
        chk("postrst_cnts", {mis_cnt, crd_cnt}, 0);
        chk("postrst_log", log_valid, 0);
        send(6'h04, 44'h0_1000_0000, 7'd0);
        tick();
        chk("postrst_table_cleared", {exp_valid, exp_tgtid, err_tgtid}, {1'b1, 7'd0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
